// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding, load-use detection and mul/div stall sequencing
// Optional HAZARD_PERF_EN adds the lu_stall_cnt/md_stall_cnt performance counters.
module hazard_forward_unit #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_ex_rs1,
   input  logic [REG_AW-1:0] id_ex_rs2,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic              id_ex_mem_read,
   input  logic              ex_mem_write_reg,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic [XLEN-1:0]   ex_mem_result,
   input  logic              mem_wb_write_reg,
   input  logic [REG_AW-1:0] mem_wb_rd,
   input  logic [XLEN-1:0]   write_back_data,
   input  logic [XLEN-1:0]   old_reg_data1,
   input  logic [XLEN-1:0]   old_reg_data2,
   input  logic              md_start,
   output logic [XLEN-1:0]   new_reg_data1,
   output logic [XLEN-1:0]   new_reg_data2,
   output logic [1:0]        fwd_sel1,
   output logic [1:0]        fwd_sel2,
   output logic              stall_if_id,
   output logic              flush_id_ex,
   output logic              stall_ex,
   output logic              md_done
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       lu_stall_cnt,
   output logic [31:0]       md_stall_cnt
`endif
);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t         state;
   logic [3:0]        cnt;
   logic              hold_valid;
   logic [REG_AW-1:0] hold_rd;
   logic [XLEN-1:0]   hold_data;
   logic              lu;
   logic              md_stall;

   function automatic logic [1:0] fwd_pick(
      input logic [REG_AW-1:0] rs,
      input logic              em_we,
      input logic [REG_AW-1:0] em_rd,
      input logic              mw_we,
      input logic [REG_AW-1:0] mw_rd,
      input logic              h_valid,
      input logic [REG_AW-1:0] h_rd
   );
      if (rs == '0)
         return 2'd0;
      else if (em_we && em_rd == rs)
         return 2'd1;
      else if (mw_we && mw_rd == rs)
         return 2'd2;
      else if (h_valid && h_rd == rs)
         return 2'd3;
      else
         return 2'd0;
   endfunction

   assign fwd_sel1 = fwd_pick(id_ex_rs1, ex_mem_write_reg, ex_mem_rd, mem_wb_write_reg,
                              mem_wb_rd, hold_valid, hold_rd);
   assign fwd_sel2 = fwd_pick(id_ex_rs2, ex_mem_write_reg, ex_mem_rd, mem_wb_write_reg,
                              mem_wb_rd, hold_valid, hold_rd);

   always_comb begin
      new_reg_data1 = old_reg_data1;
      unique case (fwd_sel1)
         2'd1:    new_reg_data1 = ex_mem_result;
         2'd2:    new_reg_data1 = write_back_data;
         2'd3:    new_reg_data1 = hold_data;
         default: new_reg_data1 = old_reg_data1;
      endcase
   end

   always_comb begin
      new_reg_data2 = old_reg_data2;
      unique case (fwd_sel2)
         2'd1:    new_reg_data2 = ex_mem_result;
         2'd2:    new_reg_data2 = write_back_data;
         2'd3:    new_reg_data2 = hold_data;
         default: new_reg_data2 = old_reg_data2;
      endcase
   end

   assign lu = id_ex_mem_read && (id_ex_rd != '0) &&
               ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

   // Stall starts combinationally in the issue cycle, before the FSM has left IDLE.
   assign md_stall = ((state == IDLE) && md_start) || ((state == BUSY) && (cnt != 4'd0));

   assign stall_ex    = !rst && md_stall;
   assign md_done     = !rst && (state == BUSY) && (cnt == 4'd0);
   assign stall_if_id = !rst && (lu || md_stall);
   assign flush_id_ex = !rst && lu && !md_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_rd    <= '0;
         hold_data  <= '0;
      end else if (!md_stall) begin
         if (mem_wb_write_reg && mem_wb_rd != '0) begin
            hold_valid <= 1'b1;
            hold_rd    <= mem_wb_rd;
            hold_data  <= write_back_data;
         end else begin
            hold_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (md_start) begin
                  cnt   <= 4'(MD_LAT - 2);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0)
                  cnt <= cnt - 4'd1;
               else
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_stall_cnt <= 32'd0;
         md_stall_cnt <= 32'd0;
      end else begin
         if (lu && !md_stall)
            lu_stall_cnt <= lu_stall_cnt + 32'd1;
         if (md_stall)
            md_stall_cnt <= md_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding unit for the pipelined core. It selects EX-stage operands from the EX/MEM result, the MEM/WB write-back value, a one-entry write-back hold register, or the register file, in that priority order. It also detects load-use hazards and sequences stalls for the multi-cycle mul/div unit. It sits between the ID/EX pipeline register and the ALU operand muxes, and drives the pipeline stall and flush controls.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width; register 0 is hardwired zero
- MD_LAT, 4, mul/div latency in cycles, legal range 2..16

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_ex_rs1, id_ex_rs2  in  REG_AW  source registers of the instruction in EX
- id_ex_rd  in  REG_AW  destination of the instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- ex_mem_write_reg  in  1  write enable for the instruction in MEM
- ex_mem_rd  in  REG_AW  destination of the instruction in MEM
- ex_mem_result  in  XLEN  ALU result of the instruction in MEM
- mem_wb_write_reg  in  1  write enable for the instruction in WB
- mem_wb_rd  in  REG_AW  destination of the instruction in WB
- write_back_data  in  XLEN  WB data
- old_reg_data1, old_reg_data2  in  XLEN  register-file operands carried in ID/EX
- md_start  in  1  mul/div op issued in EX this cycle
- new_reg_data1, new_reg_data2  out  XLEN  forwarded operands
- fwd_sel1, fwd_sel2  out  2  operand source: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB, 3 = hold
- stall_if_id  out  1  hold PC and IF/ID
- flush_id_ex  out  1  load a bubble into ID/EX
- stall_ex  out  1  hold ID/EX and suppress the EX/MEM write
- md_done  out  1  mul/div result valid this cycle

## Operation
- Operand mux for each of rs1 and rs2. The first matching source wins:
  - EX/MEM: ex_mem_write_reg, rd≠0, rd==rs
  - MEM/WB: mem_wb_write_reg, rd≠0, rd==rs
  - hold: hold_valid, hold_rd≠0, hold_rd==rs
  - otherwise the regfile value
- A source register of 0 always selects the regfile (sel 0).
- Hold register:
  - Every cycle where mem_wb_write_reg=1 and mem_wb_rd≠0, it captures mem_wb_rd and write_back_data and sets hold_valid=1.
  - Otherwise hold_valid clears.
  - Purpose: cover regfile read-before-write for the instruction that was in ID during the WB cycle.
  - The hold register does not update while stall_ex=1, so it stays coherent with the held EX instruction.
- Load-use detection:
  - lu = id_ex_mem_read & id_ex_rd≠0 & (id_ex_rd==id_rs1 | id_ex_rd==id_rs2).
  - lu drives stall_if_id=1 and flush_id_ex=1 for one cycle.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE with md_start=1: load cnt=MD_LAT-2, go to BUSY; stall_ex=1 in that same cycle (combinational).
  - BUSY with cnt≠0: stall_ex=1, decrement cnt.
  - BUSY with cnt==0: md_done=1, stall_ex=0, go to IDLE.
  - md_start is ignored in BUSY.
- Combined stall priority:
  - stall_ex=1 forces stall_if_id=1 and flush_id_ex=0; the EX instruction must not be bubbled.
  - A load-use condition in that cycle is re-evaluated after the stall releases.
- cnt is 4 bits wide.

## Timing
- Operand mux, fwd_sel, lu, stall_if_id and flush_id_ex are purely combinational; there is no added operand latency.
- Hold register, FSM and cnt update on the rising edge of clk.
- Mul/div issued in cycle 0:
  - stall_ex is high in cycles 0..MD_LAT-2.
  - md_done is high in cycle MD_LAT-1.
  - Total stall: MD_LAT-1 cycles.
- md_start in the same cycle as md_done (back-to-back ops): ignored; a new op needs the FSM in IDLE.
- Reset (asynchronous, any time including mid-BUSY):
  - state=IDLE, cnt=0, hold_valid=0, hold data=0.
  - Outputs go low immediately, except the operand outputs, which follow the combinational mux with hold invalid.

## Configuration
- HAZARD_PERF_EN defined: adds the following ports.
  - lu_stall_cnt, out, 32: increments each cycle lu causes a stall (stall_ex=0).
  - md_stall_cnt, out, 32: increments each cycle stall_ex=1.
  - Both counters wrap at 2^32 and reset to 0.
- HAZARD_PERF_EN not defined: the counters and ports are absent; all other behaviour is identical.

## Test plan
- EX/MEM and MEM/WB both write x5, with ex_mem_result=0x11 and write_back_data=0x22, and id_ex_rs1=5 -> new_reg_data1=0x11, fwd_sel1=1.
- Write to x0 with ex_mem_result=0xFFFF_FFFF and id_ex_rs2=0 -> new_reg_data2=old_reg_data2, fwd_sel2=0.
- WB writes x7=0xABCD in cycle n; in cycle n+1 nothing else writes and id_ex_rs1=7 -> new_reg_data1=0xABCD, fwd_sel1=3.
- Load to x3 in EX with id_rs2=3 -> stall_if_id=1 and flush_id_ex=1 for exactly one cycle.
- MD_LAT=4, md_start in cycle 0 -> stall_ex=1 in cycles 0-2, md_done=1 in cycle 3. rst pulsed in cycle 1 -> stall_ex=0 immediately and no md_done.
- With HAZARD_PERF_EN, the sequence above without reset -> md_stall_cnt=3, lu_stall_cnt=1.
